// File: rtl/jk_stream_driver.sv
// rtl/jk_stream_driver.sv - serialises target Q words into J/K excitation and checks the fed-back Q.
// Build option: define JK_TOGGLE_EN to drive every Q change as a toggle (J=K=1).
module jk_stream_driver #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    input  logic             err_clr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag
);
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [IDX_W-1:0] idx;
    logic             q_m;
    logic             chk_pend;
    logic             mismatch;

    // {J,K} that moves the flip-flop from cur to nxt
    function automatic logic [1:0] encode(input logic cur, input logic nxt);
`ifdef JK_TOGGLE_EN
        encode = (cur != nxt) ? 2'b11 : 2'b00;
`else
        encode = {~cur & nxt, cur & ~nxt};
`endif
    endfunction

    assign mismatch = chk_pend && (q_fb != q_m);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sr       <= '0;
            idx      <= '0;
            q_m      <= 1'b0;
            chk_pend <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            j        <= 1'b0;
            k        <= 1'b0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr       <= in_data;
                        idx      <= '0;
                        {j, k}   <= encode(q_m, in_data[0]);
                        state    <= DRIVE;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                DRIVE: begin
                    // external flip-flop takes j/k on this same edge, so q_m tracks it
                    q_m      <= sr[0];
                    sr       <= {1'b0, sr[WIDTH-1:1]};
                    idx      <= idx + 1'b1;
                    chk_pend <= 1'b1;
                    if (idx == LAST_IDX) begin
                        state  <= CHECK;
                        {j, k} <= 2'b00;
                        done   <= 1'b1;
                    end else begin
                        {j, k} <= encode(sr[0], sr[1]);
                    end
                end
                CHECK: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    chk_pend <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    chk_pend <= 1'b0;
                    {j, k}   <= 2'b00;
                end
            endcase

            // a mismatch in the clearing cycle still counts once
            if (mismatch) begin
                err_flag <= 1'b1;
                if (err_clr)
                    err_cnt <= CNT_W'(1);
                else if (err_cnt != CNT_MAX)
                    err_cnt <= err_cnt + 1'b1;
            end else if (err_clr) begin
                err_cnt  <= '0;
                err_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jk_stream_driver.sv
// tb/tb_jk_stream_driver.sv - directed bench for jk_stream_driver with an ideal external JK flip-flop.
module tb_jk_stream_driver;
    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, j, k, busy, done, err_flag;
    logic       err_clr = 1'b0;
    logic [7:0] err_cnt;
    logic       in_ready_s, j_s, k_s, busy_s, done_s, err_flag_s;
    logic [2:0] err_cnt_s;
    logic       qx;
    logic       tie0 = 1'b0;
    logic       q_fb;

    int n_cmp = 0;
    int n_err = 0;

`ifdef JK_TOGGLE_EN
    localparam logic [1:0] SETP = 2'b11;
    localparam logic [1:0] RSTP = 2'b11;
`else
    localparam logic [1:0] SETP = 2'b10;
    localparam logic [1:0] RSTP = 2'b01;
`endif
    localparam logic [1:0] HOLD = 2'b00;

    always #5 clock = ~clock;

    always @(posedge clock or negedge rst)
        if (!rst) qx <= 1'b0;
        else      qx <= (j & ~qx) | (~k & qx);

    assign q_fb = tie0 ? 1'b0 : qx;

    jk_stream_driver #(.WIDTH(8), .CNT_W(8)) dut (
        .clock(clock), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .j(j), .k(k), .q_fb(q_fb), .err_clr(err_clr),
        .busy(busy), .done(done), .err_cnt(err_cnt), .err_flag(err_flag)
    );

    jk_stream_driver #(.WIDTH(8), .CNT_W(3)) dut_s (
        .clock(clock), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_s), .j(j_s), .k(k_s), .q_fb(q_fb), .err_clr(err_clr),
        .busy(busy_s), .done(done_s), .err_cnt(err_cnt_s), .err_flag(err_flag_s)
    );

    // exp holds pair i ({j,k}) at bits [2i+1:2i]
    task automatic send_word(input logic [7:0] data, input logic [15:0] exp, input bit hold, input string name);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_timeout: in_ready=%b required 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_data  = data;
        @(posedge clock);
        #1;
        if (hold) in_data = ~data;
        else      in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            n_cmp++;
            if ({j, k, busy, done, in_ready} !== {exp[2*i +: 2], 3'b100}) begin
                n_err++;
                $display("FAIL %s drive_bit%0d: {j,k,busy,done,in_ready}=%b required %b",
                         name, i, {j, k, busy, done, in_ready}, {exp[2*i +: 2], 3'b100});
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        n_cmp++;
        if ({j, k, busy, done, in_ready} !== 5'b00110) begin
            n_err++;
            $display("FAIL %s check_cycle: {j,k,busy,done,in_ready}=%b required 00110",
                     name, {j, k, busy, done, in_ready});
        end
        @(negedge clock);
        n_cmp++;
        if ({j, k, busy, done, in_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL %s back_idle: {j,k,busy,done,in_ready}=%b required 00001",
                     name, {j, k, busy, done, in_ready});
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clock);
        #1;
        err_clr = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({in_ready, busy, j, k, done, err_flag, err_cnt} !== {6'b100000, 8'd0}) begin
            n_err++;
            $display("FAIL reset_state: {rdy,busy,j,k,done,flag,cnt}=%b required %b",
                     {in_ready, busy, j, k, done, err_flag, err_cnt}, {6'b100000, 8'd0});
        end
    endtask

    task automatic test_a5();
        send_word(8'hA5, {SETP, RSTP, SETP, HOLD, RSTP, SETP, RSTP, SETP}, 1'b0, "a5");
        n_cmp++;
        if ({err_flag, err_cnt} !== 9'd0) begin
            n_err++;
            $display("FAIL a5_errors: flag=%b cnt=%0d required 0/0", err_flag, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        send_word(8'h00, {HOLD, HOLD, HOLD, HOLD, HOLD, HOLD, HOLD, RSTP}, 1'b0, "b2b_00");
        n_cmp++;
        if ({err_flag, err_cnt} !== 9'd0) begin
            n_err++;
            $display("FAIL b2b_errors: flag=%b cnt=%0d required 0/0", err_flag, err_cnt);
        end
    endtask

    task automatic test_fault();
        tie0 = 1'b1;
        send_word(8'hFF, {HOLD, HOLD, HOLD, HOLD, HOLD, HOLD, HOLD, SETP}, 1'b0, "fault_ff");
        n_cmp++;
        if ({err_flag, err_cnt, err_cnt_s} !== {1'b1, 8'd8, 3'd7}) begin
            n_err++;
            $display("FAIL fault_count: flag=%b cnt=%0d cnt3=%0d required 1/8/7", err_flag, err_cnt, err_cnt_s);
        end
        send_word(8'hFF, 16'h0000, 1'b0, "fault_ff2");
        send_word(8'hFF, 16'h0000, 1'b0, "fault_ff3");
        n_cmp++;
        if ({err_flag_s, err_cnt, err_cnt_s} !== {1'b1, 8'd24, 3'd7}) begin
            n_err++;
            $display("FAIL fault_saturate: flag3=%b cnt=%0d cnt3=%0d required 1/24/7", err_flag_s, err_cnt, err_cnt_s);
        end
        pulse_clr();
        n_cmp++;
        if ({err_flag, err_cnt, err_flag_s, err_cnt_s} !== 13'd0) begin
            n_err++;
            $display("FAIL fault_clear: flag=%b cnt=%0d flag3=%b cnt3=%0d required all 0",
                     err_flag, err_cnt, err_flag_s, err_cnt_s);
        end
    endtask

    task automatic test_collision();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            if (c == 3) err_clr = 1'b1;
            if (c == 4) begin
                n_cmp++;
                if ({err_flag, err_cnt} !== {1'b1, 8'd1}) begin
                    n_err++;
                    $display("FAIL collision: flag=%b cnt=%0d required 1/1", err_flag, err_cnt);
                end
            end
            @(posedge clock);
            #1;
            err_clr = 1'b0;
        end
        @(negedge clock);
        n_cmp++;
        if ({err_flag, err_cnt, in_ready} !== {1'b1, 8'd7, 1'b1}) begin
            n_err++;
            $display("FAIL collision_total: flag=%b cnt=%0d rdy=%b required 1/7/1", err_flag, err_cnt, in_ready);
        end
        tie0 = 1'b0;
        pulse_clr();
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hF0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        @(negedge clock);
        n_cmp++;
        if ({j, k, busy} !== {RSTP == 2'b11 ? 2'b00 : 2'b00, 1'b1}) begin
            n_err++;
            $display("FAIL mid_before_rst: {j,k,busy}=%b required 001", {j, k, busy});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({j, k, busy, done, in_ready, err_cnt} !== {5'b00001, 8'd0}) begin
            n_err++;
            $display("FAIL mid_reset: {j,k,busy,done,rdy,cnt}=%b required %b",
                     {j, k, busy, done, in_ready, err_cnt}, {5'b00001, 8'd0});
        end
        repeat (3) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_no_done: saw_done=%b required 0", saw_done);
        end
        rst = 1'b1;
        @(negedge clock);
        send_word(8'hA5, {SETP, RSTP, SETP, HOLD, RSTP, SETP, RSTP, SETP}, 1'b1, "after_rst_hold");
        n_cmp++;
        if ({err_flag, err_cnt} !== 9'd0) begin
            n_err++;
            $display("FAIL after_rst_errors: flag=%b cnt=%0d required 0/0", err_flag, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_back_to_back();
        test_fault();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
